ball_motion: RTL and testbench
==============================

Name: ball_motion

Overview:
- Ball kinematics stage that consumes the crash detector's oCrash/oBallDie and produces the ball position it consumes as iBall_x/iBall_y.
- Parks the ball on the slider until launch, moves it on each frame tick, and reflects direction from latched crash flags.
- Tracks lives and the die/respawn/game-over sequence.

Parameters:
- X_MIN, 10, left clamp for ball centre.
- X_MAX, 630, right clamp for ball centre.
- Y_MIN, 10, top clamp for ball centre.
- Y_MAX, 479, bottom clamp for ball centre.
- PARK_OFS, 31, vertical offset of the parked ball above iSlider_y (slider half-height 20 + radius 10 + 1).
- START_LIVES, 3, lives loaded at reset (2-bit value, 1..3).
- DIE_PAUSE, 60, ticks frozen after a death.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- iTick  in  1  one-cycle frame-rate move strobe.
- iStart  in  1  launch request, level-sensitive, any cycle.
- iLevel  in  2  game level; sets speed.
- iSlider_x  in  10  slider centre x.
- iSlider_y  in  10  slider centre y.
- iCrash  in  4  {left, right, up, down} from the crash detector.
- iBallDie  in  1  ball below the floor.
- oBall_x  out  10  ball centre x.
- oBall_y  out  10  ball centre y.
- oLives  out  2  remaining lives.
- oMoving  out  1  high in MOVE.
- oGameOver  out  1  high in OVER.

Behaviour:
- Reset (rst low, async): state=IDLE, oBall_x=320, oBall_y=440, dir_x=+, dir_y=-, oLives=START_LIVES, crash latch=0, pause counter=0, step=1, oMoving=0, oGameOver=0.
- FSM states: IDLE, MOVE, DIE, OVER.
- IDLE:
  - Every clk: oBall_x<=iSlider_x; oBall_y<=iSlider_y-PARK_OFS (10-bit wrap, no clamp). Latency is 1 clk.
  - Crash latch is held at 0.
  - iStart=1 -> MOVE next clk. At that edge: dir_x=+, dir_y=-, step<=iLevel+1 (values 1..4, 3-bit). Step is frozen until the next launch.
- MOVE:
  - Crash latch: each clk, latch<=latch|iCrash. This catches single-cycle crash pulses that arrive between ticks.
  - On iTick, let L = latch|iCrash (current cycle included). Then clear latch to 0.
  - X direction from L: left only -> dir_x=+. Right only -> dir_x=-. Both -> dir_x toggles. Neither -> unchanged.
  - Y direction from L: up only -> dir_y=+ (down the screen). Down only -> dir_y=-. Both -> toggles. Neither -> unchanged.
  - Same tick: position moves using the new direction. x = x±step, y = y±step.
  - Arithmetic is 11-bit signed; result is clamped to [X_MIN,X_MAX] and [Y_MIN,Y_MAX]. No wrap-around.
  - iBallDie=1 (any clk, takes priority over iTick in the same clk) -> DIE.
    - oLives<=oLives-1, saturating at 0.
    - Pause counter<=0. Position is frozen.
- DIE:
  - Position frozen; iTick increments the pause counter.
  - When counter reaches DIE_PAUSE-1 on a tick: oLives==0 -> OVER, else IDLE.
  - iStart and iCrash are ignored.
- OVER: position frozen, oGameOver=1. Only reset exits.
- Reset mid-operation: asynchronously returns all state to reset values, whatever the FSM state.
- iStart held high through IDLE re-entry relaunches on the first IDLE clk. This is intended.

Test Plan:
- Reset -> oBall_x=320, oBall_y=440, oLives=3, oMoving=0, oGameOver=0; next clk with slider (300,450) -> ball (300,419).
- iLevel=1, iStart pulse, then 5 ticks with no crash -> ball (310,409), oMoving=1.
- In MOVE: 1-clk iCrash=4'b0010 (up) between ticks, then next tick -> y increases by step; latch reads 0 after the tick.
- iCrash=4'b1100 on the tick with dir_x=+ -> dir_x becomes -. Ball at x=629, dir + with step 2 -> x clamps to 630.
- iBallDie and iTick in the same clk -> DIE, position unchanged, oLives 3->2. After 60 ticks -> IDLE, ball tracks the slider again.
- Three deaths -> oLives=0, then OVER after the pause with oGameOver=1. iStart is ignored. rst low -> IDLE, lives=3.

Source files
------------

// File: rtl/ball_motion_if.sv
// Ball motion bus: frame strobe, launch/level controls, slider position and
// crash flags into the ball kinematics stage, ball state back out.
interface ball_motion_if;
   logic       iTick;
   logic       iStart;
   logic [1:0] iLevel;
   logic [9:0] iSlider_x;
   logic [9:0] iSlider_y;
   logic [3:0] iCrash;     // {left, right, up, down}
   logic       iBallDie;
   logic [9:0] oBall_x;
   logic [9:0] oBall_y;
   logic [1:0] oLives;
   logic       oMoving;
   logic       oGameOver;

   // Game logic side: drives the controls, observes the ball
   modport master (
      output iTick, iStart, iLevel, iSlider_x, iSlider_y, iCrash, iBallDie,
      input  oBall_x, oBall_y, oLives, oMoving, oGameOver
   );

   // Ball kinematics side
   modport slave (
      input  iTick, iStart, iLevel, iSlider_x, iSlider_y, iCrash, iBallDie,
      output oBall_x, oBall_y, oLives, oMoving, oGameOver
   );
endinterface

// File: rtl/ball_motion.sv
// Ball kinematics: parks the ball on the slider until launch, moves it one
// step per frame tick with direction reflected from latched crash flags, and
// runs the lives / die pause / game-over sequence.
module ball_motion #(
   parameter int         X_MIN       = 10,
   parameter int         X_MAX       = 630,
   parameter int         Y_MIN       = 10,
   parameter int         Y_MAX       = 479,
   parameter int         PARK_OFS    = 31,
   parameter logic [1:0] START_LIVES = 2'd3,
   parameter int         DIE_PAUSE   = 60
) (
   input  logic         clk,
   input  logic         rst,
   ball_motion_if.slave bus
);
   typedef enum logic [1:0] {IDLE, MOVE, DIE, OVER} state_t;

   localparam logic signed [10:0] X_MIN_S    = 11'(X_MIN);
   localparam logic signed [10:0] X_MAX_S    = 11'(X_MAX);
   localparam logic signed [10:0] Y_MIN_S    = 11'(Y_MIN);
   localparam logic signed [10:0] Y_MAX_S    = 11'(Y_MAX);
   localparam logic [9:0]         X_MIN_V    = 10'(X_MIN);
   localparam logic [9:0]         X_MAX_V    = 10'(X_MAX);
   localparam logic [9:0]         Y_MIN_V    = 10'(Y_MIN);
   localparam logic [9:0]         Y_MAX_V    = 10'(Y_MAX);
   localparam logic [9:0]         PARK_OFS_V = 10'(PARK_OFS);
   localparam logic [7:0]         PAUSE_LAST = 8'(DIE_PAUSE - 1);

   state_t            state_q, state_d;
   logic [9:0]        ball_x_q, ball_x_d;
   logic [9:0]        ball_y_q, ball_y_d;
   logic              dir_x_pos_q, dir_x_pos_d;  // 1: x increasing
   logic              dir_y_pos_q, dir_y_pos_d;  // 1: y increasing (down the screen)
   logic [1:0]        lives_q, lives_d;
   logic [3:0]        latch_q, latch_d;
   logic [7:0]        pause_q, pause_d;
   logic [2:0]        step_q, step_d;

   logic [3:0]        crash_all;
   logic              dir_x_new, dir_y_new;
   logic signed [10:0] step_s, x_mv, y_mv;
   logic [9:0]        x_cl, y_cl;

   // Direction update and clamped next position from latched-plus-live crash flags
   always_comb begin
      crash_all = latch_q | bus.iCrash;
      dir_x_new = dir_x_pos_q;
      if (crash_all[3] && !crash_all[2])      dir_x_new = 1'b1;
      else if (!crash_all[3] && crash_all[2]) dir_x_new = 1'b0;
      else if (crash_all[3] && crash_all[2])  dir_x_new = ~dir_x_pos_q;
      dir_y_new = dir_y_pos_q;
      if (crash_all[1] && !crash_all[0])      dir_y_new = 1'b1;
      else if (!crash_all[1] && crash_all[0]) dir_y_new = 1'b0;
      else if (crash_all[1] && crash_all[0])  dir_y_new = ~dir_y_pos_q;
      step_s = signed'({8'b0, step_q});
      x_mv   = dir_x_new ? signed'({1'b0, ball_x_q}) + step_s
                         : signed'({1'b0, ball_x_q}) - step_s;
      y_mv   = dir_y_new ? signed'({1'b0, ball_y_q}) + step_s
                         : signed'({1'b0, ball_y_q}) - step_s;
      x_cl = x_mv[9:0];
      if (x_mv < X_MIN_S)      x_cl = X_MIN_V;
      else if (x_mv > X_MAX_S) x_cl = X_MAX_V;
      y_cl = y_mv[9:0];
      if (y_mv < Y_MIN_S)      y_cl = Y_MIN_V;
      else if (y_mv > Y_MAX_S) y_cl = Y_MAX_V;
   end

   // Next-state and datapath updates for the park / move / die / over sequence
   always_comb begin
      state_d     = state_q;
      ball_x_d    = ball_x_q;
      ball_y_d    = ball_y_q;
      dir_x_pos_d = dir_x_pos_q;
      dir_y_pos_d = dir_y_pos_q;
      lives_d     = lives_q;
      latch_d     = latch_q;
      pause_d     = pause_q;
      step_d      = step_q;
      case (state_q)
         IDLE: begin
            ball_x_d = bus.iSlider_x;
            ball_y_d = bus.iSlider_y - PARK_OFS_V;  // wraps by design
            latch_d  = 4'b0;
            if (bus.iStart) begin
               state_d     = MOVE;
               dir_x_pos_d = 1'b1;
               dir_y_pos_d = 1'b0;
               step_d      = {1'b0, bus.iLevel} + 3'd1;
            end
         end
         MOVE: begin
            if (bus.iBallDie) begin
               state_d = DIE;
               lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
               pause_d = 8'd0;
               latch_d = 4'b0;
            end else if (bus.iTick) begin
               dir_x_pos_d = dir_x_new;
               dir_y_pos_d = dir_y_new;
               ball_x_d    = x_cl;
               ball_y_d    = y_cl;
               latch_d     = 4'b0;
            end else begin
               latch_d = crash_all;
            end
         end
         DIE: begin
            if (bus.iTick) begin
               if (pause_q == PAUSE_LAST) begin
                  pause_d = 8'd0;
                  state_d = (lives_q == 2'd0) ? OVER : IDLE;
               end else begin
                  pause_d = pause_q + 8'd1;
               end
            end
         end
         OVER: begin
         end
         default: state_d = IDLE;
      endcase
   end

   // State register with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         ball_x_q    <= 10'd320;
         ball_y_q    <= 10'd440;
         dir_x_pos_q <= 1'b1;
         dir_y_pos_q <= 1'b0;
         lives_q     <= START_LIVES;
         latch_q     <= 4'b0;
         pause_q     <= 8'd0;
         step_q      <= 3'd1;
      end else begin
         state_q     <= state_d;
         ball_x_q    <= ball_x_d;
         ball_y_q    <= ball_y_d;
         dir_x_pos_q <= dir_x_pos_d;
         dir_y_pos_q <= dir_y_pos_d;
         lives_q     <= lives_d;
         latch_q     <= latch_d;
         pause_q     <= pause_d;
         step_q      <= step_d;
      end
   end

   assign bus.oBall_x   = ball_x_q;
   assign bus.oBall_y   = ball_y_q;
   assign bus.oLives    = lives_q;
   assign bus.oMoving   = (state_q == MOVE);
   assign bus.oGameOver = (state_q == OVER);
endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion: directed game sequence with randomized
// noise, every cycle compared against a plain-arithmetic game model.
module tb_ball_motion;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   ball_motion_if bus();

   ball_motion dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model: phase 0 parked, 1 flying, 2 dying, 3 game over
   int       m_phase, m_x, m_y, m_dx, m_dy, m_lives, m_pause, m_step;
   bit [3:0] m_seen;

   task automatic model_reset();
      m_phase = 0; m_x = 320; m_y = 440; m_dx = 1; m_dy = -1;
      m_lives = 3; m_pause = 0; m_step = 1; m_seen = 4'b0;
   endtask

   task automatic model_clk();
      bit hit_l, hit_r, hit_u, hit_d;
      if (m_phase == 0) begin
         m_x = int'(bus.iSlider_x);
         m_y = (int'(bus.iSlider_y) + 1024 - 31) % 1024;
         m_seen = 4'b0;
         if (bus.iStart) begin
            m_phase = 1; m_dx = 1; m_dy = -1; m_step = int'(bus.iLevel) + 1;
         end
      end else if (m_phase == 1) begin
         if (bus.iBallDie) begin
            m_lives = (m_lives > 0) ? m_lives - 1 : 0;
            m_pause = 0; m_phase = 2; m_seen = 4'b0;
         end else if (bus.iTick) begin
            {hit_l, hit_r, hit_u, hit_d} = m_seen | bus.iCrash;
            if (hit_l && hit_r) m_dx = -m_dx;
            else if (hit_l)     m_dx = 1;
            else if (hit_r)     m_dx = -1;
            if (hit_u && hit_d) m_dy = -m_dy;
            else if (hit_u)     m_dy = 1;
            else if (hit_d)     m_dy = -1;
            m_x = m_x + m_dx * m_step;
            m_y = m_y + m_dy * m_step;
            if (m_x < 10)  m_x = 10;
            if (m_x > 630) m_x = 630;
            if (m_y < 10)  m_y = 10;
            if (m_y > 479) m_y = 479;
            m_seen = 4'b0;
         end else begin
            m_seen = m_seen | bus.iCrash;
         end
      end else if (m_phase == 2) begin
         if (bus.iTick) begin
            if (m_pause == 59) begin
               m_pause = 0;
               m_phase = (m_lives == 0) ? 3 : 0;
            end else begin
               m_pause++;
            end
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("ball_x", 32'(bus.oBall_x), m_x);
      chk("ball_y", 32'(bus.oBall_y), m_y);
      chk("lives", 32'(bus.oLives), m_lives);
      chk("moving", 32'(bus.oMoving), (m_phase == 1) ? 1 : 0);
      chk("game_over", 32'(bus.oGameOver), (m_phase == 3) ? 1 : 0);
      $display("t=%0t x=%0d y=%0d lives=%0d moving=%0b over=%0b", $time,
               bus.oBall_x, bus.oBall_y, bus.oLives, bus.oMoving, bus.oGameOver);
   endtask

   task automatic clk_step();
      model_clk();
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic quiet();
      bus.iTick = 1'b0; bus.iStart = 1'b0; bus.iCrash = 4'b0; bus.iBallDie = 1'b0;
   endtask

   task automatic tick();
      bus.iTick = 1'b1; clk_step();
      bus.iTick = 1'b0; clk_step();
   endtask

   task automatic noise();
      bus.iCrash = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      bus.iStart = 1'($urandom);
      bus.iLevel = 2'($urandom);
   endtask

   task automatic random_play(input int n);
      for (int i = 0; i < n; i++) begin
         noise();
         bus.iTick     = ($urandom_range(0, 2) == 0);
         bus.iSlider_x = 10'($urandom);
         bus.iSlider_y = 10'($urandom);
         clk_step();
      end
      quiet();
   endtask

   task automatic die_pause(input bit hold_start);
      bus.iBallDie = 1'b1; bus.iTick = 1'b1; clk_step();
      quiet();
      for (int i = 0; i < 60; i++) begin
         noise();
         if (hold_start) bus.iStart = 1'b1;
         bus.iTick = 1'b1; clk_step();
         bus.iTick = 1'b0; bus.iCrash = 4'b0;
         if (!hold_start) bus.iStart = 1'b0;
         if (i != 59) clk_step();
      end
   endtask

   initial begin
      quiet();
      bus.iLevel = 2'd0; bus.iSlider_x = 10'd300; bus.iSlider_y = 10'd450;
      #3 rst = 1'b0;
      model_reset();
      #2;
      chk("rst_x", 32'(bus.oBall_x), 320);
      chk("rst_y", 32'(bus.oBall_y), 440);
      chk("rst_lives", 32'(bus.oLives), 3);
      chk("rst_moving", 32'(bus.oMoving), 0);
      chk("rst_over", 32'(bus.oGameOver), 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;

      // Parked ball follows slider with one clock latency
      clk_step();
      chk("park_x", 32'(bus.oBall_x), 300);
      chk("park_y", 32'(bus.oBall_y), 419);

      // Launch at level 1 (step 2), five clean ticks
      bus.iLevel = 2'd1; bus.iStart = 1'b1; clk_step(); bus.iStart = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("fly_x", 32'(bus.oBall_x), 310);
      chk("fly_y", 32'(bus.oBall_y), 409);
      chk("fly_moving", 32'(bus.oMoving), 1);

      // Single-cycle up crash between ticks is caught by the latch
      bus.iCrash = 4'b0010; clk_step(); bus.iCrash = 4'b0; clk_step();
      bus.iTick = 1'b1; clk_step(); bus.iTick = 1'b0;
      chk("latched_up_y", 32'(bus.oBall_y), 411);
      chk("latched_up_x", 32'(bus.oBall_x), 312);

      // Left+right on the tick toggles dir_x from + to -
      bus.iCrash = 4'b1100; bus.iTick = 1'b1; clk_step(); quiet();
      chk("toggle_x", 32'(bus.oBall_x), 310);
      chk("toggle_y", 32'(bus.oBall_y), 413);

      // Death coinciding with a tick: position frozen, one life lost
      bus.iBallDie = 1'b1; bus.iTick = 1'b1; clk_step(); quiet();
      chk("die_x", 32'(bus.oBall_x), 310);
      chk("die_y", 32'(bus.oBall_y), 413);
      chk("die_lives", 32'(bus.oLives), 2);
      for (int i = 0; i < 60; i++) begin
         noise(); bus.iTick = 1'b1; clk_step();
         quiet(); clk_step();
      end
      chk("respawn_moving", 32'(bus.oMoving), 0);
      bus.iSlider_x = 10'd301; bus.iSlider_y = 10'd470; clk_step();
      chk("respawn_x", 32'(bus.oBall_x), 301);
      chk("respawn_y", 32'(bus.oBall_y), 439);

      // Fly right until x=629 with step 2, then clamp at the right wall
      bus.iLevel = 2'd1; bus.iStart = 1'b1; clk_step(); bus.iStart = 1'b0;
      for (int i = 0; i < 400 && m_x != 629; i++) tick();
      chk("pre_clamp_x", 32'(bus.oBall_x), 629);
      tick();
      chk("clamp_x", 32'(bus.oBall_x), 630);

      // Random crashes, ticks, level and slider noise while flying
      random_play(400);

      // Second death with iStart held: relaunch on the first parked clock
      die_pause(1'b1);
      chk("lives_after_2", 32'(bus.oLives), 1);
      clk_step();
      chk("relaunch_moving", 32'(bus.oMoving), 1);
      bus.iStart = 1'b0;
      random_play(300);

      // Third death ends the game
      die_pause(1'b0);
      chk("final_lives", 32'(bus.oLives), 0);
      chk("final_over", 32'(bus.oGameOver), 1);
      random_play(40);
      chk("over_sticky", 32'(bus.oGameOver), 1);
      chk("over_not_moving", 32'(bus.oMoving), 0);

      // Asynchronous reset from OVER
      #2 rst = 1'b0;
      model_reset();
      #1;
      chk("rst2_lives", 32'(bus.oLives), 3);
      chk("rst2_over", 32'(bus.oGameOver), 0);
      chk("rst2_x", 32'(bus.oBall_x), 320);
      chk("rst2_y", 32'(bus.oBall_y), 440);
      @(posedge clk);
      #1 rst = 1'b1;
      bus.iSlider_x = 10'd100; bus.iSlider_y = 10'd200;
      clk_step();
      chk("rst2_park_y", 32'(bus.oBall_y), 169);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
